// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage RV32I core.
// Owns the fetch PC, drives the instruction-memory address and registers
// fetched instructions into the IF/ID pipeline register for decode.
module fetch_stage #(
    parameter int unsigned            word_width = 32,
    parameter logic [word_width-1:0]  RESET_PC   = '0,
    parameter logic [word_width-1:0]  NOP_INSTR  = word_width'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  PCSrcE,
    input  logic [word_width-1:0] PCTargetE,
    output logic [word_width-1:0] imem_addr,
    input  logic [word_width-1:0] imem_rdata,
    input  logic                  imem_ready,
    output logic [word_width-1:0] PCF,
    output logic [word_width-1:0] InstrD,
    output logic [word_width-1:0] PCD,
    output logic [word_width-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic                  MisalignF
);

    // Fetch-side state
    logic [word_width-1:0] pc_q, pc_d;
    logic [word_width-1:0] pcplus4_f;
    logic [word_width-1:0] target_aligned;
    logic                  misalign_q, misalign_d;

    // IF/ID pipeline register
    logic [word_width-1:0] instr_q, instr_d;
    logic [word_width-1:0] pcd_q, pcd_d;
    logic [word_width-1:0] pcp4d_q, pcp4d_d;
    logic                  valid_q, valid_d;

    // Sequential PC increment; wraps modulo 2^word_width.
    assign pcplus4_f      = pc_q + word_width'(4);
    // Redirect targets are forced onto a word boundary.
    assign target_aligned = {PCTargetE[word_width-1:2], 2'b00};

    // Next fetch PC: redirect beats stall and memory wait, else step by 4.
    always_comb begin
        pc_d = pc_q;
        if (PCSrcE) begin
            pc_d = target_aligned;
        end else if (StallF || !imem_ready) begin
            pc_d = pc_q;
        end else begin
            pc_d = pcplus4_f;
        end
    end

    // Sticky flag for any redirect whose target was not word aligned.
    always_comb begin
        misalign_d = misalign_q;
        if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    // IF/ID next state: flush beats stall; a memory wait inserts a bubble.
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4d_d = pcp4d_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = '0;
            pcp4d_d = '0;
            valid_d = 1'b0;
        end else if (StallD) begin
            instr_d = instr_q;
            pcd_d   = pcd_q;
            pcp4d_d = pcp4d_q;
            valid_d = valid_q;
        end else if (imem_ready) begin
            instr_d = imem_rdata;
            pcd_d   = pc_q;
            pcp4d_d = pcplus4_f;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            pcd_d   = '0;
            pcp4d_d = '0;
            valid_d = 1'b0;
        end
    end

    // Fetch-side registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // IF/ID register with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pcp4d_q <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4d_q <= pcp4d_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign PCF       = pc_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4d_q;
    assign ValidD    = valid_q;
    assign MisalignF = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic for fetch_stage,
// checked against a cycle-level behavioural model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, PCSrcE, imem_ready;
    logic [31:0] PCTargetE, imem_rdata;
    logic [31:0] imem_addr, PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, MisalignF;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4;
    logic        m_valid, m_mis;

    fetch_stage #(
        .word_width(32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .MisalignF (MisalignF)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Set all inputs for the coming edge (called at negedge).
    task automatic drive(input logic rst, input logic sf, input logic sd, input logic fd,
                         input logic br, input logic [31:0] tgt,
                         input logic rdy, input logic [31:0] rdata);
        reset = rst; StallF = sf; StallD = sd; FlushD = fd;
        PCSrcE = br; PCTargetE = tgt; imem_ready = rdy; imem_rdata = rdata;
    endtask

    // One clock: the model applies the pipeline rules to the inputs seen at the edge.
    task automatic tick();
        logic [31:0] old_pc;
        old_pc = m_pc;
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h0; m_mis = 1'b0;
            m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 1'b0;
        end else begin
            if (FlushD || (!StallD && !imem_ready)) begin
                m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 1'b0;
            end else if (!StallD) begin
                m_instr = imem_rdata; m_pcd = old_pc; m_pcp4 = old_pc + 32'd4; m_valid = 1'b1;
            end
            if (PCSrcE) begin
                m_pc = PCTargetE & 32'hFFFF_FFFC;
                if (PCTargetE % 4 != 0) m_mis = 1'b1;
            end else if (!StallF && imem_ready) begin
                m_pc = old_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic normal(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 32'h0, 1, ADDI);
            tick();
        end
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 32'h0, 1, ADDI);
        tick();
    endtask

    task automatic test_reset();
        // Reset asserted during a stall and a redirect must still win.
        drive(1, 1, 1, 0, 1, 32'h0000_0123, 0, 32'hDEAD_BEEF);
        tick();
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf: got %h want %h", PCF, 32'h0); end
        checks++; if (InstrD !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", InstrD, NOP); end
        checks++; if ({PCD, PCPlus4D} !== 64'h0) begin errors++; $display("FAIL reset_pcd: got %h/%h want 0/0", PCD, PCPlus4D); end
        checks++; if ({ValidD, MisalignF} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b want 00", ValidD, MisalignF); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            normal(1);
            exp_pc = 32'(i * 4);
            checks++; if (PCF !== exp_pc || imem_addr !== exp_pc) begin errors++; $display("FAIL seq_pcf[%0d]: got %h/%h want %h", i, PCF, imem_addr, exp_pc); end
            checks++; if (InstrD !== ADDI || ValidD !== 1'b1) begin errors++; $display("FAIL seq_instr[%0d]: got %h v=%b want %h v=1", i, InstrD, ValidD, ADDI); end
            checks++; if (PCD !== exp_pc - 4 || PCPlus4D !== exp_pc) begin errors++; $display("FAIL seq_pcd[%0d]: got %h/%h want %h/%h", i, PCD, PCPlus4D, exp_pc - 4, exp_pc); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        normal(2);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 0, 32'h0, 1, 32'h1111_1111);
            tick();
            checks++; if (PCF !== 32'h8) begin errors++; $display("FAIL stall_pcf[%0d]: got %h want %h", i, PCF, 32'h8); end
            checks++; if (InstrD !== ADDI || PCD !== 32'h4 || ValidD !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %h %h v=%b want %h 4 v=1", i, InstrD, PCD, ValidD, ADDI); end
        end
        normal(1);
        checks++; if (PCF !== 32'hC || PCD !== 32'h8) begin errors++; $display("FAIL stall_release: got pcf=%h pcd=%h want c/8", PCF, PCD); end
        // Flush together with stall: flush wins.
        drive(0, 1, 1, 1, 0, 32'h0, 1, ADDI);
        tick();
        checks++; if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h0) begin errors++; $display("FAIL flush_over_stall: got %h v=%b pcd=%h want %h v=0 pcd=0", InstrD, ValidD, PCD, NOP); end
    endtask

    task automatic test_redirect();
        do_reset();
        normal(4);
        drive(0, 0, 0, 1, 1, 32'h40, 1, 32'h2222_2222);
        tick();
        checks++; if (PCF !== 32'h40) begin errors++; $display("FAIL redir_pcf: got %h want %h", PCF, 32'h40); end
        checks++; if (InstrD !== NOP || ValidD !== 1'b0) begin errors++; $display("FAIL redir_squash: got %h v=%b want %h v=0", InstrD, ValidD, NOP); end
        normal(1);
        checks++; if (PCD !== 32'h40 || ValidD !== 1'b1 || PCPlus4D !== 32'h44) begin errors++; $display("FAIL redir_arrive: got pcd=%h p4=%h v=%b want 40/44/1", PCD, PCPlus4D, ValidD); end
        // Redirect beats StallF.
        drive(0, 1, 0, 1, 1, 32'h80, 1, ADDI);
        tick();
        checks++; if (PCF !== 32'h80) begin errors++; $display("FAIL redir_over_stall: got %h want %h", PCF, 32'h80); end
        // Redirect near the top of the address space, then wrap.
        drive(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, ADDI);
        tick();
        normal(1);
        checks++; if (PCF !== 32'h0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin errors++; $display("FAIL wrap: got pcf=%h pcd=%h p4=%h want 0/fffffffc/0", PCF, PCD, PCPlus4D); end
    endtask

    task automatic test_imem_wait();
        do_reset();
        normal(8);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h3333_3333);
            tick();
            checks++; if (PCF !== 32'h20) begin errors++; $display("FAIL wait_pcf[%0d]: got %h want %h", i, PCF, 32'h20); end
            checks++; if (InstrD !== NOP || ValidD !== 1'b0) begin errors++; $display("FAIL wait_bubble[%0d]: got %h v=%b want %h v=0", i, InstrD, ValidD, NOP); end
        end
        normal(1);
        checks++; if (PCD !== 32'h20 || ValidD !== 1'b1 || PCF !== 32'h24) begin errors++; $display("FAIL wait_resume: got pcd=%h v=%b pcf=%h want 20/1/24", PCD, ValidD, PCF); end
    endtask

    task automatic test_misalign();
        do_reset();
        normal(2);
        drive(0, 0, 0, 1, 1, 32'h42, 1, ADDI);
        tick();
        checks++; if (PCF !== 32'h40 || MisalignF !== 1'b1) begin errors++; $display("FAIL misalign_set: got pcf=%h m=%b want 40/1", PCF, MisalignF); end
        normal(10);
        checks++; if (MisalignF !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b want 1", MisalignF); end
        do_reset();
        checks++; if (MisalignF !== 1'b0 || PCF !== 32'h0) begin errors++; $display("FAIL misalign_clear: got m=%b pcf=%h want 0/0", MisalignF, PCF); end
    endtask

    task automatic test_random();
        logic br;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            br = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 49) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0,
                  br ? 1'b1 : ($urandom_range(0, 15) == 0),
                  br,
                  $urandom(),
                  $urandom_range(0, 4) != 0,
                  $urandom());
            tick();
            checks++; if (PCF !== m_pc || imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pcf[%0d]: got %h/%h want %h", i, PCF, imem_addr, m_pc); end
            checks++; if (InstrD !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, InstrD, m_instr); end
            checks++; if (PCD !== m_pcd || PCPlus4D !== m_pcp4) begin errors++; $display("FAIL rnd_pcd[%0d]: got %h/%h want %h/%h", i, PCD, PCPlus4D, m_pcd, m_pcp4); end
            checks++; if (ValidD !== m_valid || MisalignF !== m_mis) begin errors++; $display("FAIL rnd_flags[%0d]: got v=%b m=%b want v=%b m=%b", i, ValidD, MisalignF, m_valid, m_mis); end
        end
    endtask

    initial begin
        m_pc = 0; m_instr = NOP; m_pcd = 0; m_pcp4 = 0; m_valid = 0; m_mis = 0;
        drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_imem_wait();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
